// File: rtl/aes_key_expand.sv
// aes_key_expand: iterative AES-128 key schedule, streams round keys 0..10 on a valid/ready port.
// Define AES_KEYEXP_REVERSE_EN to pre-expand into a key array and stream rounds 10..0 instead.
module aes_key_expand #(
  parameter int NUM_ROUNDS = 10,
  parameter int RK_IDX_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [127:0]        key_in,
  input  logic                key_load,
  output logic                ready,
  output logic [127:0]        rk_out,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic [RK_IDX_W-1:0] rk_round,
  output logic                done
);

  if (NUM_ROUNDS != 10) begin : g_bad_cfg
    $error("aes_key_expand: only NUM_ROUNDS=10 (AES-128) is supported");
  end

  typedef enum logic [1:0] {S_IDLE, S_OUT, S_CALC, S_EXPAND} state_t;

  localparam logic [RK_IDX_W-1:0] LAST_RND = RK_IDX_W'(NUM_ROUNDS);

`ifdef AES_KEYEXP_REVERSE_EN
  localparam state_t                FIRST_WORK = S_EXPAND;
  localparam state_t                AFTER_XFER = S_OUT;
  localparam logic [RK_IDX_W-1:0]   END_RND    = '0;
`else
  localparam state_t                FIRST_WORK = S_OUT;
  localparam state_t                AFTER_XFER = S_CALC;
  localparam logic [RK_IDX_W-1:0]   END_RND    = LAST_RND;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254 by square-and-multiply) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int unsigned i = 0; i < 7; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  state_t       state;
  state_t       state_nx;
  logic [7:0]   rcon;
  logic         xfer;
  logic [127:0] key_nx;

`ifdef AES_KEYEXP_REVERSE_EN
  logic [127:0] keys [0:NUM_ROUNDS];
`endif

  assign rk_valid = (state == S_OUT);
  assign xfer     = rk_valid && rk_ready;
  // Holding ready low during the done cycle keeps a new load from overlapping the finish.
  assign ready    = (state == S_IDLE) && !done;
  assign key_nx   = next_key(rk_out, rcon);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (key_load && ready) state_nx = FIRST_WORK;
      S_OUT:    if (xfer) state_nx = (rk_round == END_RND) ? S_IDLE : AFTER_XFER;
      S_CALC:   state_nx = S_OUT;
      S_EXPAND: if (rk_round == LAST_RND - 1'b1) state_nx = S_OUT;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      rk_out   <= '0;
      rk_round <= '0;
      rcon     <= 8'h01;
      done     <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (key_load && ready) begin
            rk_out   <= key_in;
            rk_round <= '0;
            rcon     <= 8'h01;
`ifdef AES_KEYEXP_REVERSE_EN
            keys[0]  <= key_in;
`endif
          end
        end
        S_OUT: begin
          if (xfer) begin
            if (rk_round == END_RND) begin
              done <= 1'b1;
            end
`ifdef AES_KEYEXP_REVERSE_EN
            else begin
              rk_out   <= keys[rk_round - 1'b1];
              rk_round <= rk_round - 1'b1;
            end
`endif
          end
        end
        S_CALC, S_EXPAND: begin
          rk_out   <= key_nx;
          rk_round <= rk_round + 1'b1;
          rcon     <= xtime(rcon);
`ifdef AES_KEYEXP_REVERSE_EN
          keys[rk_round + 1'b1] <= key_nx;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand: FIPS-197 word-level key schedule model, randomized keys and stalls.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_load;
  logic         ready;
  logic [127:0] rk_out;
  logic         rk_valid;
  logic         rk_ready;
  logic [3:0]   rk_round;
  logic         done;

  aes_key_expand #(.NUM_ROUNDS(10), .RK_IDX_W(4)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load), .ready(ready),
    .rk_out(rk_out), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_round(rk_round), .done(done)
  );

  always #5 clk = ~clk;

`ifdef AES_KEYEXP_REVERSE_EN
  localparam bit REVERSE   = 1'b1;
  localparam int FIRST_LAT = 11;
`else
  localparam bit REVERSE   = 1'b0;
  localparam int FIRST_LAT = 1;
`endif
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] key;
    bit           last;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         e_pop;
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  int           load_cyc = 0;
  int           first_lat = -1;
  int           last_lat = -1;
  int           done_cnt = 0;
  bit           first_pending = 1'b0;
  bit           exp_done = 1'b0;
  bit           stalled = 1'b0;
  bit           stall_mode = 1'b0;
  logic [127:0] hold_key;
  logic [3:0]   hold_rnd;
  logic [7:0]   sb [256];
  logic [7:0]   rcon_tbl [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [127:0] model_rk [11];
  logic [127:0] got [11];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Carry-less product reduced modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    logic [15:0] poly;
    p = '0;
    poly = 16'h011b;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'h00, a} << i);
    for (int bt = 14; bt >= 8; bt--) if (p[bt]) p = p ^ (poly << (bt - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c63;
    c63 = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++) if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c63[i];
      sb[x] = s;
    end
  endtask

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rcon_tbl[i / 4 - 1], 24'h0};
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r < 11; r++) model_rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  task automatic do_load(input logic [127:0] k);
    exp_t e;
    int   n;
    int   r;
    n = 0;
    while (!ready && n < 100) begin @(posedge clk); #1; n++; end
    chk("ready_before_load", ready, 1);
    model_expand(k);
    for (int i = 0; i < 11; i++) begin
      r = REVERSE ? 10 - i : i;
      e.rnd  = 4'(r);
      e.key  = model_rk[r];
      e.last = (i == 10);
      exp_q.push_back(e);
    end
    for (int i = 0; i < 11; i++) got[i] = '0;
    load_cyc      = cyc;
    first_pending = 1'b1;
    done_cnt      = 0;
    key_in        = k;
    key_load      = 1'b1;
    @(posedge clk); #1;
    key_load = 1'b0;
    key_in   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_done) && n < 3000) begin @(posedge clk); #1; n++; end
    if (n >= 3000) begin
      failures++;
      $display("FAIL schedule_timeout actual=%0d keys outstanding required=0", exp_q.size());
      exp_q.delete();
    end
    chk("done_pulse_count", 128'(done_cnt), 1);
  endtask

  task automatic wait_round(input int r);
    int n;
    n = 0;
    while (!(rk_valid && rk_round == 4'(r)) && n < 300) begin @(posedge clk); #1; n++; end
    chk("reach_round", (rk_valid && rk_round == 4'(r)), 1);
  endtask

  // Monitor: samples on the falling edge, a transfer happens at the following rising edge.
  always @(negedge clk) begin
    if (rst) begin
      stalled  = 1'b0;
      exp_done = 1'b0;
    end else begin
      if (exp_done) begin
        chk("done_after_last", done, 1);
        exp_done = 1'b0;
      end
      if (done) done_cnt++;
      if (stalled) begin
        chk("valid_held", rk_valid, 1);
        if (rk_valid) begin
          chk("stall_key_stable", rk_out, hold_key);
          chk("stall_round_stable", rk_round, hold_rnd);
        end
      end
      stalled = 1'b0;
      if (rk_valid) begin
        if (first_pending) begin
          first_lat     = cyc - load_cyc;
          first_pending = 1'b0;
        end
        if (rk_ready) begin
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_key actual=round %0d key %0h required=no transfer", rk_round, rk_out);
          end else begin
            e_pop = exp_q.pop_front();
            chk("key_round", rk_round, e_pop.rnd);
            chk("key_value", rk_out, e_pop.key);
            if (rk_round <= 4'd10) got[rk_round] = rk_out;
            if (e_pop.last) begin
              exp_done = 1'b1;
              last_lat = cyc - load_cyc;
            end
          end
        end else begin
          stalled  = 1'b1;
          hold_key = rk_out;
          hold_rnd = rk_round;
        end
      end
    end
  end

  initial begin
    rk_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      rk_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    key_load = 1'b0;
    key_in   = '0;
    build_sbox();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", ready, 1);
    chk("reset_rk_valid", rk_valid, 0);
    chk("reset_rk_out", rk_out, 0);
    chk("reset_rk_round", rk_round, 0);
    chk("reset_done", done, 0);
    rst = 1'b0;

    do_load(FIPS_KEY);
    wait_done();
    chk("fips_round0", got[0], FIPS_KEY);
    chk("fips_round1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips_round10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("first_latency", 128'(first_lat), 128'(FIRST_LAT));
    chk("schedule_cycles", 128'(last_lat), 21);

    do_load('0);
    wait_done();
    chk("zero_round1", got[1], 128'h62636363626363636263636362636363);
    chk("zero_round10", got[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    stall_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_load({$urandom, $urandom, $urandom, $urandom});
      wait_done();
    end
    stall_mode = 1'b0;

    do_load({$urandom, $urandom, $urandom, $urandom});
    wait_round(4);
    key_in   = ~key_in;
    key_load = 1'b1;
    chk("busy_ready_low", ready, 0);
    @(posedge clk); #1;
    key_load = 1'b0;
    wait_done();

    do_load(FIPS_KEY);
    wait_round(6);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_rk_valid", rk_valid, 0);
    chk("rst_ready", ready, 1);
    chk("rst_rk_round", rk_round, 0);
    chk("rst_rk_out", rk_out, 0);
    chk("rst_done", done, 0);
    exp_q.delete();
    first_pending = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_no_valid", rk_valid, 0);

    do_load(FIPS_KEY);
    wait_done();
    chk("rerun_round0", got[0], FIPS_KEY);
    chk("rerun_round1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("rerun_round10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("rerun_first_latency", 128'(first_lat), 128'(FIRST_LAT));
    chk("rerun_schedule_cycles", 128'(last_lat), 21);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
